// File: rtl/alu_issue.sv
// Issue/collect front-end for the ALU: queues decoded ops, issues one at a time,
// waits for the result (or times out) and hands it to the register-file writeback port.
module alu_issue #(
    parameter int LEN_DATA     = 64,
    parameter int LEN_TYPE_ALU = 4,
    parameter int LEN_REG_ADDR = 5,
    parameter int QDEPTH       = 2,
    parameter int TIMEOUT      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LEN_DATA-1:0]       in_A,
    input  logic [LEN_DATA-1:0]       in_B,
    input  logic [LEN_DATA/2-1:0]     in_Imm,
    input  logic [LEN_TYPE_ALU-1:0]   in_code,
    input  logic [LEN_REG_ADDR-1:0]   in_rd,
    output logic                      alu_en,
    output logic [LEN_DATA-1:0]       alu_A,
    output logic [LEN_DATA-1:0]       alu_B,
    output logic [LEN_DATA/2-1:0]     alu_Imm,
    output logic [LEN_TYPE_ALU-1:0]   alu_code,
    input  logic [LEN_DATA-1:0]       alu_result,
    input  logic                      alu_cout,
    input  logic                      alu_rdy,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [LEN_REG_ADDR-1:0]   wb_rd,
    output logic [LEN_DATA-1:0]       wb_data,
    output logic                      wb_cout,
    output logic                      wb_err,
    output logic                      busy
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = LEN_DATA / 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

    typedef struct packed {
        logic [LEN_DATA-1:0]     a;
        logic [LEN_DATA-1:0]     b;
        logic [IW-1:0]           imm;
        logic [LEN_TYPE_ALU-1:0] code;
        logic [LEN_REG_ADDR-1:0] rd;
    } op_t;

    op_t                     mem_q [QDEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q;
    logic                    push, pop, full, empty, head_legal;
    op_t                     head;

    state_t                  state_q, state_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [LEN_REG_ADDR-1:0] rd_q, rd_d;
    logic [LEN_DATA-1:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [IW-1:0]           alu_imm_q, alu_imm_d;
    logic [LEN_TYPE_ALU-1:0] alu_code_q, alu_code_d;
    logic [LEN_DATA-1:0]     wb_data_q, wb_data_d;
    logic                    wb_cout_q, wb_cout_d, wb_err_q, wb_err_d;
    logic                    take_next;

    assign full       = (count_q == CW'(QDEPTH));
    assign empty      = (count_q == '0);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign head       = mem_q[rd_ptr_q];
    assign head_legal = (head.code >= LEN_TYPE_ALU'(1)) && (head.code <= LEN_TYPE_ALU'(13));

    // NOTE: queue storage has no reset; only pointers and count are cleared, which flushes it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_A, in_B, in_Imm, in_code, in_rd};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        rd_d       = rd_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_imm_d  = alu_imm_q;
        alu_code_d = alu_code_q;
        wb_data_d  = wb_data_q;
        wb_cout_d  = wb_cout_q;
        wb_err_d   = wb_err_q;
        take_next  = 1'b0;
        pop        = 1'b0;

        case (state_q)
            S_IDLE:  take_next = !empty;
            S_ISSUE: begin
                state_d = S_WAIT;
                tcnt_d  = '0;
            end
            S_WAIT: begin
                if (alu_rdy) begin
                    state_d   = S_WB;
                    wb_data_d = alu_result;
                    wb_cout_d = alu_cout;
                    wb_err_d  = 1'b0;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d   = S_WB;
                    wb_data_d = '0;
                    wb_cout_d = 1'b0;
                    wb_err_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_WB: begin
                if (wb_ready) begin
                    state_d   = S_IDLE;
                    take_next = !empty;
                end
            end
        endcase

        // Illegal codes bypass the ALU and report an error writeback directly.
        if (take_next) begin
            pop  = 1'b1;
            rd_d = head.rd;
            if (head_legal) begin
                state_d    = S_ISSUE;
                alu_a_d    = head.a;
                alu_b_d    = head.b;
                alu_imm_d  = head.imm;
                alu_code_d = head.code;
            end else begin
                state_d   = S_WB;
                wb_data_d = '0;
                wb_cout_d = 1'b0;
                wb_err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            tcnt_q     <= '0;
            rd_q       <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_imm_q  <= '0;
            alu_code_q <= '0;
            wb_data_q  <= '0;
            wb_cout_q  <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            rd_q       <= rd_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_imm_q  <= alu_imm_d;
            alu_code_q <= alu_code_d;
            wb_data_q  <= wb_data_d;
            wb_cout_q  <= wb_cout_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign alu_en   = (state_q == S_ISSUE);
    assign alu_A    = alu_a_q;
    assign alu_B    = alu_b_q;
    assign alu_Imm  = alu_imm_q;
    assign alu_code = alu_code_q;
    assign wb_valid = (state_q == S_WB);
    assign wb_rd    = rd_q;
    assign wb_data  = wb_data_q;
    assign wb_cout  = wb_cout_q;
    assign wb_err   = wb_err_q;
    assign busy     = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: an ALU stand-in answers issues, and a push-order
// scoreboard predicts every writeback from the ops as pushed.
module tb_alu_issue;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_A = '0, in_B = '0;
    logic [31:0] in_Imm = '0;
    logic [3:0]  in_code = '0;
    logic [4:0]  in_rd = '0;
    logic        alu_en;
    logic [63:0] alu_A, alu_B;
    logic [31:0] alu_Imm;
    logic [3:0]  alu_code;
    logic [63:0] alu_result = '0;
    logic        alu_cout = 1'b0;
    logic        alu_rdy = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_cout, wb_err, busy;

    alu_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_A(in_A), .in_B(in_B),
        .in_Imm(in_Imm), .in_code(in_code), .in_rd(in_rd),
        .alu_en(alu_en), .alu_A(alu_A), .alu_B(alu_B), .alu_Imm(alu_Imm), .alu_code(alu_code),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_rdy(alu_rdy),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_cout(wb_cout), .wb_err(wb_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
        logic        cout;
        logic        err;
    } wb_s;

    int  n_checks = 0;
    int  n_fail   = 0;
    wb_s exp_q[$];
    wb_s obs_q[$];
    int  en_cycles[$];
    int  cyc = 0;
    int  en_count = 0;
    bit  saw_not_ready = 0;
    int  lat_cfg = 1;        // 0: ALU never answers, <0: random latency 1..4
    bit  stray_rdy = 0;
    bit  wbr_rand = 0;
    logic wbr_fixed = 1'b1;

    // Arbitrary but deterministic ALU behaviour; the issuer only forwards what it returns.
    function automatic logic [64:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                            input logic [31:0] imm, input logic [3:0] code);
        case (code)
            4'd1:    return {1'b0, a} + {1'b0, b};
            4'd2:    return {1'b0, a - b};
            default: return {1'b0, a ^ {32'd0, imm} ^ {60'd0, code}};
        endcase
    endfunction

    // ALU stand-in and writeback monitor; everything here acts on the falling edge.
    int          countdown = 0;
    logic [64:0] pend = '0;
    always @(negedge clk) begin
        cyc++;
        wb_ready = wbr_rand ? 1'($urandom) : wbr_fixed;
        if (wb_valid && wb_ready) obs_q.push_back(wb_s'({wb_rd, wb_data, wb_cout, wb_err}));
        if (!in_ready) saw_not_ready = 1;
        alu_rdy = stray_rdy;
        if (stray_rdy) {alu_cout, alu_result} = {1'b1, 64'hDEAD_BEEF_CAFE_F00D};
        if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
                alu_rdy = 1'b1;
                {alu_cout, alu_result} = pend;
            end
        end
        if (alu_en) begin
            en_count++;
            en_cycles.push_back(cyc);
            pend      = ref_alu(alu_A, alu_B, alu_Imm, alu_code);
            countdown = (lat_cfg < 0) ? int'($urandom_range(4, 1)) : lat_cfg;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_op(input logic [63:0] a, input logic [63:0] b, input logic [31:0] imm,
                           input logic [3:0] code, input logic [4:0] rd, input bit will_timeout);
        int w = 0;
        logic [64:0] r;
        in_valid = 1'b1; in_A = a; in_B = b; in_Imm = imm; in_code = code; in_rd = rd;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (w >= 200) begin
            n_fail++;
            $display("FAIL push_ready: in_ready stuck low, got 0 required 1");
        end else if (code == 4'd0 || code > 4'd13 || will_timeout) begin
            exp_q.push_back(wb_s'({rd, 64'd0, 1'b0, 1'b1}));
        end else begin
            r = ref_alu(a, b, imm, code);
            exp_q.push_back(wb_s'({rd, r[63:0], r[64], 1'b0}));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int w = 0;
        while (obs_q.size() < exp_q.size() && w < 1000) begin
            @(negedge clk);
            w++;
        end
        ok = (obs_q.size() == exp_q.size());
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b required 0", wb_valid); end
        n_checks++; if (alu_en !== 1'b0)   begin n_fail++; $display("FAIL reset_alu_en: got %b required 0", alu_en); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++;
        if ({alu_A, alu_B, alu_Imm, alu_code} !== '0) begin
            n_fail++; $display("FAIL reset_alu_ops: got %h %h %h %h required 0", alu_A, alu_B, alu_Imm, alu_code);
        end
        n_checks++;
        if ({wb_rd, wb_data, wb_cout, wb_err} !== '0) begin
            n_fail++; $display("FAIL reset_wb_fields: got %h %h %b %b required 0", wb_rd, wb_data, wb_cout, wb_err);
        end
    endtask

    task automatic test_single;
        int en0 = en_count;
        bit ok;
        wb_s e, o;
        lat_cfg = 1; wbr_fixed = 1'b1;
        push_op(64'd5, 64'd7, 32'd0, 4'd1, 5'd3, 0);
        wait_drain(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_drain: got %0d wbs required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL single_wb: got %h required %h", o, e); end
        end
        n_checks++; if (en_count - en0 != 1) begin n_fail++; $display("FAIL single_en: got %0d pulses required 1", en_count - en0); end
    endtask

    task automatic test_back_to_back;
        int en0 = en_count;
        bit ok;
        wb_s e, o;
        saw_not_ready = 0;
        en_cycles.delete();
        lat_cfg = 1; wbr_fixed = 1'b1;
        for (int i = 0; i < 3; i++)
            push_op({$urandom, $urandom}, {$urandom, $urandom}, $urandom, 4'($urandom_range(13, 1)), 5'($urandom), 0);
        wait_drain(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_drain: got %0d wbs required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL b2b_wb: got %h required %h", o, e); end
        end
        n_checks++; if (!saw_not_ready) begin n_fail++; $display("FAIL b2b_ready_drop: got in_ready never low required low once"); end
        n_checks++; if (en_count - en0 != 3) begin n_fail++; $display("FAIL b2b_en: got %0d pulses required 3", en_count - en0); end
        n_checks++;
        if (en_cycles.size() != 3 || en_cycles[1] - en_cycles[0] != 3 || en_cycles[2] - en_cycles[1] != 3) begin
            n_fail++; $display("FAIL b2b_spacing: got %0d pulses with uneven spacing required 3 pulses 3 cycles apart", en_cycles.size());
        end
    endtask

    task automatic test_backpressure;
        int en0, w = 0;
        bit ok, stable = 1;
        logic [63:0] d0;
        wb_s e, o;
        lat_cfg = 2; wbr_fixed = 1'b0;
        for (int i = 0; i < 2; i++)
            push_op({$urandom, $urandom}, {$urandom, $urandom}, $urandom, 4'($urandom_range(13, 1)), 5'($urandom), 0);
        while (!wb_valid && w < 100) begin @(negedge clk); w++; end
        n_checks++; if (!wb_valid) begin n_fail++; $display("FAIL bp_wb_valid: got 0 required 1"); end
        d0 = wb_data; en0 = en_count;
        repeat (10) begin
            @(negedge clk);
            if (wb_valid !== 1'b1 || wb_data !== d0) stable = 0;
        end
        n_checks++; if (!stable) begin n_fail++; $display("FAIL bp_stable: got wb changed under stall required held %h", d0); end
        n_checks++; if (en_count != en0) begin n_fail++; $display("FAIL bp_no_en: got %0d pulses required 0", en_count - en0); end
        wbr_fixed = 1'b1;
        w = 0;
        while (en_count == en0 && w < 20) begin @(negedge clk); w++; end
        n_checks++; if (en_count == en0) begin n_fail++; $display("FAIL bp_next_issue: got 0 pulses required 1"); end
        wait_drain(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_drain: got %0d wbs required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL bp_wb: got %h required %h", o, e); end
        end
    endtask

    task automatic test_illegal;
        int en0 = en_count;
        bit ok;
        wb_s e, o;
        logic [3:0] codes [3] = '{4'd0, 4'd14, 4'd15};
        lat_cfg = 1; wbr_fixed = 1'b1;
        foreach (codes[i])
            push_op({$urandom, $urandom}, {$urandom, $urandom}, $urandom, codes[i], 5'($urandom), 0);
        wait_drain(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL illegal_drain: got %0d wbs required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL illegal_wb: got %h required %h", o, e); end
        end
        n_checks++; if (en_count != en0) begin n_fail++; $display("FAIL illegal_en: got %0d pulses required 0", en_count - en0); end
    endtask

    task automatic test_timeout;
        int w = 0, t = 0;
        bit ok, idle_ok = 1;
        wb_s e, o;
        lat_cfg = 0; wbr_fixed = 1'b0;
        push_op({$urandom, $urandom}, {$urandom, $urandom}, $urandom, 4'd1, 5'd9, 1);
        while (!alu_en && w < 50) begin @(negedge clk); w++; end
        while (!wb_valid && t < 100) begin @(negedge clk); t++; end
        n_checks++; if (t != TO + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles en-to-wb required %0d", t, TO + 1); end
        stray_rdy = 1;
        repeat (3) @(negedge clk);
        stray_rdy = 0;
        @(negedge clk);
        n_checks++;
        if (wb_data !== 64'd0 || wb_err !== 1'b1 || wb_cout !== 1'b0) begin
            n_fail++; $display("FAIL timeout_late_rdy: got data=%h err=%b cout=%b required 0 1 0", wb_data, wb_err, wb_cout);
        end
        wbr_fixed = 1'b1;
        wait_drain(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL timeout_drain: got %0d wbs required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL timeout_wb: got %h required %h", o, e); end
        end
        repeat (2) @(negedge clk);
        stray_rdy = 1;
        repeat (3) begin @(negedge clk); if (wb_valid !== 1'b0 || busy !== 1'b0) idle_ok = 0; end
        stray_rdy = 0;
        n_checks++; if (!idle_ok) begin n_fail++; $display("FAIL idle_rdy_ignored: got wb_valid/busy set required 0"); end
        lat_cfg = 1;
    endtask

    task automatic test_reset_mid;
        int en0;
        bit ok;
        wb_s e, o;
        lat_cfg = 6; wbr_fixed = 1'b1;
        push_op({$urandom, $urandom}, {$urandom, $urandom}, $urandom, 4'd1, 5'd1, 0);
        push_op({$urandom, $urandom}, {$urandom, $urandom}, $urandom, 4'd2, 5'd2, 0);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got busy=%b in_ready=%b required 1 1", busy, in_ready); end
        rst = 1'b0;
        #1;
        n_checks++; if (wb_valid !== 1'b0 || alu_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_strobes: got wb_valid=%b alu_en=%b required 0 0", wb_valid, alu_en); end
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_status: got in_ready=%b busy=%b required 1 0", in_ready, busy); end
        n_checks++;
        if ({alu_A, alu_code, wb_data, wb_err, wb_rd} !== '0) begin
            n_fail++; $display("FAIL rstmid_fields: got alu_A=%h code=%h wb_data=%h err=%b rd=%h required 0", alu_A, alu_code, wb_data, wb_err, wb_rd);
        end
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        rst = 1'b1;
        en0 = en_count;
        repeat (15) @(negedge clk);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rstmid_stale_wb: got %0d wbs required 0", obs_q.size()); end
        n_checks++; if (en_count != en0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_flushed: got %0d pulses busy=%b required 0 0", en_count - en0, busy); end
        lat_cfg = 1;
        push_op(64'd100, 64'd1, 32'd0, 4'd2, 5'd17, 0);
        wait_drain(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmid_drain: got %0d wbs required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL rstmid_wb: got %h required %h", o, e); end
        end
    endtask

    task automatic test_random;
        int en0 = en_count, n_legal = 0;
        bit ok;
        wb_s e, o;
        logic [3:0] c;
        lat_cfg = -1; wbr_rand = 1;
        for (int i = 0; i < 40; i++) begin
            c = 4'($urandom_range(15, 0));
            if (c >= 4'd1 && c <= 4'd13) n_legal++;
            push_op({$urandom, $urandom}, {$urandom, $urandom}, $urandom, c, 5'($urandom), 0);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        wait_drain(ok);
        wbr_rand = 0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_drain: got %0d wbs required %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL rand_wb: got %h required %h", o, e); end
        end
        n_checks++; if (en_count - en0 != n_legal) begin n_fail++; $display("FAIL rand_en: got %0d pulses required %0d", en_count - en0, n_legal); end
        lat_cfg = 1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_random();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
